alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Consumer and back end of the ALU reservation station (RS).
- Picks one ready RS entry per cycle and registers its operands.
- Executes the ALU or compare operation in a 2-stage pipeline.
- Drives the per-entry `broadcast_bus` that frees the RS slot, and the tag/data result port that feeds the ROB.

Parameters:
- `size`, 8: number of RS entries. This is the width of the `ready` vector and the `broadcast_bus` array.
- `rob_size`, 8: number of ROB entries. The tag width is fixed at 4 bits.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `flush`  in  1  pipeline flush (mispredict); same effect as `rst`
- `rs_data[size]`  in  `rs_t`  RS entries: `tag`, `r1`, `r2`, `alu_opcode`, `cmp_opcode`, `valid`
- `acu_operation[size]`  in  1 each  1 = compare op, 0 = ALU op
- `ready`  in  `size`  RS entry has both operands resolved
- `broadcast_bus[size]`  out  `sal_t`  per-entry completion: `rdy`, `tag`, `data`
- `cdb_valid`  out  1  result valid to ROB
- `cdb_tag`  out  4  ROB tag of the result
- `cdb_data`  out  32  result value
- `in_flight`  out  `size`  entries issued but not yet broadcast (debug/visibility)

Behaviour:
- Reset/flush: all `broadcast_bus[i].rdy`=0 (`data`/`tag`=0), `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `in_flight`=0, both pipeline stage valids=0, round-robin pointer=0.
  - Any op in flight at reset/flush is dropped; nothing is broadcast for it.
  - `rst`/`flush` take priority over every other update in the same cycle.
- Eligibility: entry i is eligible when `ready[i]`=1, `rs_data[i].valid`=1 and `in_flight[i]`=0.
- Select (combinational, cycle N): choose one eligible entry.
  - Fixed priority: lowest index wins.
  - With the Optional Feature: round-robin, see that section.
  - No eligible entry means no issue.
- S1, issue register (edge ending cycle N): latch `idx`, `tag`, `r1`, `r2`, `alu_opcode`, `cmp_opcode`, `acu_operation`; set `s1_valid`=1 and `in_flight[idx]`=1.
- S2, execute register (edge ending cycle N+1): compute from S1 and register the result; set `s2_valid`=1.
  - ALU ops (`alu_ops` enum): add, sub (r1-r2), sll/srl by r2[4:0], sra arithmetic by r2[4:0], xor, or, and. All results are 32-bit and wrap on overflow.
  - Compare ops (`cmp_ops`): beq, bne, blt/bge signed, bltu/bgeu unsigned. Result is {31'b0, cond}.
- Broadcast (cycle N+2, exactly one cycle wide):
  - `broadcast_bus[s2_idx].rdy`=1, with `.data`=result and `.tag`=tag. All other entries have `rdy`=0.
  - `cdb_valid`=1, `cdb_tag`=tag, `cdb_data`=result.
  - `in_flight[s2_idx]` clears at the edge ending cycle N+2.
- Latency: `ready` sampled in cycle N gives a broadcast in cycle N+2.
  - Throughput is 1 op/cycle and the pipeline never stalls.
  - At most one `broadcast_bus` entry is asserted per cycle.
- An entry kept `ready` while `in_flight` is never reissued.
- If an entry is issued and broadcast on the same index, the S1 set of `in_flight` wins over the S2 clear. This case is only reachable after reuse.
- Operands are captured at issue. Later changes to `rs_data` do not affect an op in flight.
- All `size` entries eligible at once: they issue over `size` consecutive cycles and broadcast on `size` consecutive cycles.

Optional Feature:
- Macro: `ALU_ISSUE_RR_EN`.
- Defined: round-robin select.
  - The search starts at the pointer and wraps modulo `size`.
  - After an issue of entry k, the pointer becomes (k+1) mod `size`.
  - The pointer is unchanged when nothing issues.
- Undefined: fixed lowest-index priority and no pointer register.

Test Plan:
- `ready[3]`=1, alu_add, r1=5, r2=7, tag=2, held 1 cycle → cycle N+2: `broadcast_bus[3].rdy`=1, `data`=12, `cdb_tag`=2; `rdy`=0 in N+3.
- `acu_operation[0]`=1, bltu, r1=1, r2=0xFFFFFFFF → `cdb_data`=1; then bge, r1=0xFFFFFFFF (-1), r2=0 → `cdb_data`=0.
- alu_sub, r1=3, r2=5 → 0xFFFFFFFE; alu_sra, r1=0x80000000, r2=0x24 (shift 4) → 0xF8000000.
- `ready[0..2]` all held high → broadcasts in order 0, 1, 2 in cycles N+2..N+4, each entry exactly once; with `ALU_ISSUE_RR_EN` and pointer=1, order is 1, 2, 0.
- Issue entry 5 in cycle N, assert `flush` in N+1 → no `broadcast_bus`/`cdb_valid` in N+2; `in_flight`=0.
- Assert `rst` with S1 and S2 both full → all outputs 0 next cycle; a fresh `ready[1]` afterwards completes normally at +2.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// Shared types and the RS <-> issue-unit bus for the ALU issue back end.
// The package carries the RS entry, broadcast record and opcode enums so that
// the reservation station, the issue unit and the bench agree on one layout.
package alu_issue_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_SLL = 3'd2,
      ALU_SRL = 3'd3,
      ALU_SRA = 3'd4,
      ALU_XOR = 3'd5,
      ALU_OR  = 3'd6,
      ALU_AND = 3'd7
   } alu_ops;

   typedef enum logic [2:0] {
      CMP_BEQ  = 3'd0,
      CMP_BNE  = 3'd1,
      CMP_BLT  = 3'd2,
      CMP_BGE  = 3'd3,
      CMP_BLTU = 3'd4,
      CMP_BGEU = 3'd5
   } cmp_ops;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] r1;
      logic [31:0] r2;
      alu_ops      alu_opcode;
      cmp_ops      cmp_opcode;
      logic        valid;
   } rs_t;

   typedef struct packed {
      logic        rdy;
      logic [3:0]  tag;
      logic [31:0] data;
   } sal_t;

endpackage

interface alu_issue_if #(
   parameter int unsigned size = 8
);
   import alu_issue_pkg::*;

   rs_t              rs_data       [size];
   logic             acu_operation [size];
   logic [size-1:0]  ready;
   sal_t             broadcast_bus [size];
   logic             cdb_valid;
   logic [3:0]       cdb_tag;
   logic [31:0]      cdb_data;
   logic [size-1:0]  in_flight;

   // Reservation-station side: offers entries, consumes completions.
   modport master (
      output rs_data, acu_operation, ready,
      input  broadcast_bus, cdb_valid, cdb_tag, cdb_data, in_flight
   );

   // Issue-unit side.
   modport slave (
      input  rs_data, acu_operation, ready,
      output broadcast_bus, cdb_valid, cdb_tag, cdb_data, in_flight
   );

endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: picks one ready RS entry per cycle, executes it in a
// two-stage pipeline (S1 issue register, S2 execute register) and broadcasts
// the result to the RS slot and the ROB result port in the following cycle.
// Optional build macro ALU_ISSUE_RR_EN: round-robin select instead of fixed
// lowest-index priority.
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int unsigned size     = 8,
   parameter int unsigned rob_size = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   alu_issue_if.slave  bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned IDX_W  = (size > 1) ? $clog2(size) : 1;

   // The ROB tag is a fixed 4-bit field; a larger ROB cannot be addressed.
   if (rob_size > (1 << TAG_W)) begin : g_rob_size_check
      $error("alu_issue_unit: rob_size exceeds the 4-bit tag range");
   end

   function automatic logic [DATA_W-1:0] alu_exec(
      input alu_ops            op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic signed [DATA_W-1:0] a_s;
      logic [4:0]               sh;
      a_s = a;
      sh  = b[4:0];
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLL: return a << sh;
         ALU_SRL: return a >> sh;
         ALU_SRA: return a_s >>> sh;
         ALU_XOR: return a ^ b;
         ALU_OR:  return a | b;
         ALU_AND: return a & b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] cmp_exec(
      input cmp_ops            op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic signed [DATA_W-1:0] a_s;
      logic signed [DATA_W-1:0] b_s;
      logic                     c;
      a_s = a;
      b_s = b;
      case (op)
         CMP_BEQ:  c = (a == b);
         CMP_BNE:  c = (a != b);
         CMP_BLT:  c = (a_s <  b_s);
         CMP_BGE:  c = (a_s >= b_s);
         CMP_BLTU: c = (a <  b);
         CMP_BGEU: c = (a >= b);
         default:  c = 1'b0;
      endcase
      return {{(DATA_W-1){1'b0}}, c};
   endfunction

   // Control state
   logic               vld_p1_q;
   logic               vld_p2_q;
   logic [size-1:0]    in_flight_q;
   logic [size-1:0]    in_flight_d;

   // S1 data
   logic [IDX_W-1:0]   idx_p1_q;
   logic [TAG_W-1:0]   tag_p1_q;
   logic [DATA_W-1:0]  r1_p1_q;
   logic [DATA_W-1:0]  r2_p1_q;
   alu_ops             alu_op_p1_q;
   cmp_ops             cmp_op_p1_q;
   logic               acu_p1_q;

   // S2 data
   logic [IDX_W-1:0]   idx_p2_q;
   logic [TAG_W-1:0]   tag_p2_q;
   logic [DATA_W-1:0]  res_p2_q;

   logic [size-1:0]    elig;
   logic               issue;
   logic [IDX_W-1:0]   sel_idx;

`ifdef ALU_ISSUE_RR_EN
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;

   // Round-robin select: first eligible entry at or after the pointer.
   always_comb begin
      int k;
      issue   = 1'b0;
      sel_idx = '0;
      k       = 0;
      for (int i = 0; i < size; i++) begin
         elig[i] = bus.ready[i] & bus.rs_data[i].valid & ~in_flight_q[i];
      end
      // Walk from farthest to nearest so the nearest eligible entry wins.
      for (int j = int'(size) - 1; j >= 0; j--) begin
         k = (int'(ptr_q) + j) % int'(size);
         if (elig[k]) begin
            issue   = 1'b1;
            sel_idx = IDX_W'(k);
         end
      end
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (int'(sel_idx) == int'(size) - 1) ? '0 : sel_idx + 1'b1;
      end
   end

   // Pointer advances past the entry just issued; held when idle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed-priority select: lowest eligible index wins.
   always_comb begin
      issue   = 1'b0;
      sel_idx = '0;
      for (int i = 0; i < size; i++) begin
         elig[i] = bus.ready[i] & bus.rs_data[i].valid & ~in_flight_q[i];
      end
      for (int i = int'(size) - 1; i >= 0; i--) begin
         if (elig[i]) begin
            issue   = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end
`endif

   // In-flight bookkeeping: the S2 clear is applied first so a same-index
   // issue in the same cycle leaves the bit set.
   always_comb begin
      in_flight_d = in_flight_q;
      if (vld_p2_q) begin
         in_flight_d[idx_p2_q] = 1'b0;
      end
      if (issue) begin
         in_flight_d[sel_idx] = 1'b1;
      end
   end

   // Stage valids and in-flight mask; reset/flush drop everything in flight.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         in_flight_q <= '0;
      end else begin
         vld_p1_q    <= issue;
         vld_p2_q    <= vld_p1_q;
         in_flight_q <= in_flight_d;
      end
   end

   // ---- p0 -> p1: capture operands of the selected entry at issue ----
   always_ff @(posedge clk) begin
      if (issue) begin
         idx_p1_q    <= sel_idx;
         tag_p1_q    <= bus.rs_data[sel_idx].tag;
         r1_p1_q     <= bus.rs_data[sel_idx].r1;
         r2_p1_q     <= bus.rs_data[sel_idx].r2;
         alu_op_p1_q <= bus.rs_data[sel_idx].alu_opcode;
         cmp_op_p1_q <= bus.rs_data[sel_idx].cmp_opcode;
         acu_p1_q    <= bus.acu_operation[sel_idx];
      end
   end

   // ---- p1 -> p2: execute and register the result ----
   always_ff @(posedge clk) begin
      idx_p2_q <= idx_p1_q;
      tag_p2_q <= tag_p1_q;
      res_p2_q <= acu_p1_q ? cmp_exec(cmp_op_p1_q, r1_p1_q, r2_p1_q)
                           : alu_exec(alu_op_p1_q, r1_p1_q, r2_p1_q);
   end

   // ---- p2 outputs: one-cycle broadcast, data forced to zero when idle ----
   always_comb begin
      for (int i = 0; i < size; i++) begin
         bus.broadcast_bus[i] = '0;
         if (vld_p2_q && (idx_p2_q == IDX_W'(i))) begin
            bus.broadcast_bus[i].rdy  = 1'b1;
            bus.broadcast_bus[i].tag  = tag_p2_q;
            bus.broadcast_bus[i].data = res_p2_q;
         end
      end
      bus.cdb_valid = vld_p2_q;
      bus.cdb_tag   = vld_p2_q ? tag_p2_q : '0;
      bus.cdb_data  = vld_p2_q ? res_p2_q : '0;
      bus.in_flight = in_flight_q;
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: a vector table of single ops with
// hand-computed results, plus sequences for back-to-back issue, flush and
// reset with a full pipeline.
module tb_alu_issue_unit;
   import alu_issue_pkg::*;

   localparam int SZ = 8;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   alu_issue_if #(.size(SZ)) bus ();

   alu_issue_unit #(.size(SZ), .rob_size(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic        acu;
      alu_ops      aop;
      cmp_ops      cop;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [3:0]  tag;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int idx, input logic acu, input alu_ops aop, input cmp_ops cop,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] tag,
                          input logic [31:0] exp, input string name);
      vec_t v;
      v.idx = idx; v.acu = acu; v.aop = aop; v.cop = cop;
      v.r1 = r1; v.r2 = r2; v.tag = tag; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < SZ; i++) begin
         bus.rs_data[i]       = '0;
         bus.acu_operation[i] = 1'b0;
      end
      bus.ready = '0;
   endtask

   task automatic load_entry(input int idx, input logic acu, input alu_ops aop, input cmp_ops cop,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] tag);
      bus.rs_data[idx].tag        = tag;
      bus.rs_data[idx].r1         = r1;
      bus.rs_data[idx].r2         = r2;
      bus.rs_data[idx].alu_opcode = aop;
      bus.rs_data[idx].cmp_opcode = cop;
      bus.rs_data[idx].valid      = 1'b1;
      bus.acu_operation[idx]      = acu;
   endtask

   function automatic int rdy_count();
      int c = 0;
      for (int i = 0; i < SZ; i++) c += int'(bus.broadcast_bus[i].rdy);
      return c;
   endfunction

   // Run one op through the pipe with ready held for exactly one cycle.
   task automatic run_single(input vec_t v);
      clear_inputs();
      load_entry(v.idx, v.acu, v.aop, v.cop, v.r1, v.r2, v.tag);
      bus.ready[v.idx] = 1'b1;
      tick();
      bus.ready = '0;
      chk({v.name, " in_flight@N+1"}, 32'(bus.in_flight), 32'(1) << v.idx);
      tick();
      chk({v.name, " cdb_valid"}, 32'(bus.cdb_valid), 32'd1);
      chk({v.name, " cdb_tag"}, 32'(bus.cdb_tag), 32'(v.tag));
      chk({v.name, " cdb_data"}, bus.cdb_data, v.exp);
      chk({v.name, " bus.rdy"}, 32'(bus.broadcast_bus[v.idx].rdy), 32'd1);
      chk({v.name, " bus.data"}, bus.broadcast_bus[v.idx].data, v.exp);
      chk({v.name, " rdy_count"}, 32'(rdy_count()), 32'd1);
      tick();
      chk({v.name, " cdb_valid@N+3"}, 32'(bus.cdb_valid), 32'd0);
      chk({v.name, " rdy_count@N+3"}, 32'(rdy_count()), 32'd0);
      chk({v.name, " in_flight@N+3"}, 32'(bus.in_flight), 32'd0);
   endtask

   initial begin
      int order[3];

      rst   = 1'b1;
      flush = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("reset cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("reset cdb_tag", 32'(bus.cdb_tag), 32'd0);
      chk("reset cdb_data", bus.cdb_data, 32'd0);
      chk("reset in_flight", 32'(bus.in_flight), 32'd0);
      chk("reset rdy_count", 32'(rdy_count()), 32'd0);

      // Vector table: entry, cmp?, alu op, cmp op, r1, r2, tag, expected result
      add_vec(3, 1'b0, ALU_ADD, CMP_BEQ,  32'd5,          32'd7,          4'd2, 32'd12,         "add");
      add_vec(0, 1'b1, ALU_ADD, CMP_BLTU, 32'd1,          32'hFFFF_FFFF,  4'd1, 32'd1,          "bltu");
      add_vec(0, 1'b1, ALU_ADD, CMP_BGE,  32'hFFFF_FFFF,  32'd0,          4'd3, 32'd0,          "bge");
      add_vec(1, 1'b0, ALU_SUB, CMP_BEQ,  32'd3,          32'd5,          4'd4, 32'hFFFF_FFFE,  "sub");
      add_vec(2, 1'b0, ALU_SRA, CMP_BEQ,  32'h8000_0000,  32'h24,         4'd5, 32'hF800_0000,  "sra");
      add_vec(4, 1'b0, ALU_SLL, CMP_BEQ,  32'd1,          32'h3F,         4'd6, 32'h8000_0000,  "sll");
      add_vec(5, 1'b0, ALU_SRL, CMP_BEQ,  32'h8000_0000,  32'd4,          4'd7, 32'h0800_0000,  "srl");
      add_vec(6, 1'b0, ALU_XOR, CMP_BEQ,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd0, 32'hFF00_FF00,  "xor");
      add_vec(7, 1'b0, ALU_OR,  CMP_BEQ,  32'h12,         32'h21,         4'd1, 32'h33,         "or");
      add_vec(7, 1'b0, ALU_AND, CMP_BEQ,  32'hFF00_FF00,  32'h0FF0_0FF0,  4'd2, 32'h0F00_0F00,  "and");
      add_vec(2, 1'b0, ALU_ADD, CMP_BEQ,  32'hFFFF_FFFF,  32'd2,          4'd3, 32'd1,          "add_wrap");
      add_vec(1, 1'b1, ALU_ADD, CMP_BEQ,  32'd7,          32'd7,          4'd4, 32'd1,          "beq");
      add_vec(1, 1'b1, ALU_ADD, CMP_BNE,  32'd7,          32'd7,          4'd5, 32'd0,          "bne");
      add_vec(6, 1'b1, ALU_ADD, CMP_BLT,  32'hFFFF_FFFF,  32'd0,          4'd6, 32'd1,          "blt");
      add_vec(6, 1'b1, ALU_ADD, CMP_BLTU, 32'hFFFF_FFFF,  32'd0,          4'd7, 32'd0,          "bltu_big");
      add_vec(3, 1'b1, ALU_ADD, CMP_BGEU, 32'hFFFF_FFFF,  32'd0,          4'd8, 32'd1,          "bgeu");

      foreach (vq[i]) run_single(vq[i]);

      // Entries 0..2 ready together for three cycles
`ifdef ALU_ISSUE_RR_EN
      // Move the pointer to 1 by issuing entry 0 alone first.
      clear_inputs();
      load_entry(0, 1'b0, ALU_ADD, CMP_BEQ, 32'd0, 32'd0, 4'd0);
      bus.ready[0] = 1'b1;
      tick();
      bus.ready = '0;
      tick();
      tick();
      order = '{1, 2, 0};
`else
      order = '{0, 1, 2};
`endif
      clear_inputs();
      for (int i = 0; i < 3; i++) load_entry(i, 1'b0, ALU_ADD, CMP_BEQ, 32'(10 * i), 32'd1, 4'(9 + i));
      bus.ready[2:0] = 3'b111;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("burst[%0d] cdb_valid", k), 32'(bus.cdb_valid), 32'd1);
         chk($sformatf("burst[%0d] cdb_tag", k), 32'(bus.cdb_tag), 32'(9 + order[k]));
         chk($sformatf("burst[%0d] cdb_data", k), bus.cdb_data, 32'(10 * order[k] + 1));
         chk($sformatf("burst[%0d] rdy", k), 32'(bus.broadcast_bus[order[k]].rdy), 32'd1);
         chk($sformatf("burst[%0d] rdy_count", k), 32'(rdy_count()), 32'd1);
         tick();
         if (k == 0) bus.ready = '0;
      end
      chk("burst end cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("burst end in_flight", 32'(bus.in_flight), 32'd0);

      // Ready held for 3 cycles on one entry: in-flight entry is not reissued
      clear_inputs();
      load_entry(6, 1'b0, ALU_ADD, CMP_BEQ, 32'd40, 32'd2, 4'd6);
      bus.ready[6] = 1'b1;
      tick();
      tick();
      chk("hold bcast", 32'(bus.cdb_data), 32'd42);
      tick();
      bus.ready = '0;
      chk("hold no reissue N+3", 32'(bus.cdb_valid), 32'd0);
      tick();
      chk("hold no reissue N+4", 32'(bus.cdb_valid), 32'd0);
      tick();

      // Flush one cycle after issue
      clear_inputs();
      load_entry(5, 1'b0, ALU_ADD, CMP_BEQ, 32'd1, 32'd1, 4'd5);
      bus.ready[5] = 1'b1;
      tick();
      bus.ready = '0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("flush rdy[5]", 32'(bus.broadcast_bus[5].rdy), 32'd0);
      chk("flush in_flight", 32'(bus.in_flight), 32'd0);
      tick();
      chk("flush cdb_valid+1", 32'(bus.cdb_valid), 32'd0);

      // Reset with S1 and S2 both full
      clear_inputs();
      load_entry(3, 1'b0, ALU_ADD, CMP_BEQ, 32'd100, 32'd1, 4'd3);
      load_entry(4, 1'b0, ALU_ADD, CMP_BEQ, 32'd200, 32'd1, 4'd4);
      bus.ready[3] = 1'b1;
      tick();
      bus.ready = '0;
      bus.ready[4] = 1'b1;
      tick();
      bus.ready = '0;
      chk("pre-rst cdb_tag", 32'(bus.cdb_tag), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst cdb_valid", 32'(bus.cdb_valid), 32'd0);
      chk("rst cdb_tag", 32'(bus.cdb_tag), 32'd0);
      chk("rst cdb_data", bus.cdb_data, 32'd0);
      chk("rst in_flight", 32'(bus.in_flight), 32'd0);
      chk("rst rdy_count", 32'(rdy_count()), 32'd0);
      tick();
      chk("rst S1 dropped", 32'(bus.cdb_valid), 32'd0);

      // Fresh op after reset
      clear_inputs();
      load_entry(1, 1'b0, ALU_ADD, CMP_BEQ, 32'd20, 32'd22, 4'd9);
      bus.ready[1] = 1'b1;
      tick();
      bus.ready = '0;
      tick();
      chk("post-rst cdb_valid", 32'(bus.cdb_valid), 32'd1);
      chk("post-rst rdy[1]", 32'(bus.broadcast_bus[1].rdy), 32'd1);
      chk("post-rst cdb_data", bus.cdb_data, 32'd42);
      chk("post-rst cdb_tag", 32'(bus.cdb_tag), 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
